// File: rtl/pio_dmem_pkg.sv
// Shared definitions for the wide PIO data memory: FSM encoding and lane helpers.
// PIO bus width defaults to 32 bits unless PIO_NBITS is already defined.
`ifndef PIO_NBITS
`define PIO_NBITS 32
`endif
`ifndef PIO_RANGE
`define PIO_RANGE `PIO_NBITS-1:0
`endif

package pio_dmem_pkg;

    typedef logic [2:0] pio_state_t;

    localparam pio_state_t ST_IDLE  = 3'd0;
    localparam pio_state_t ST_PEND  = 3'd1;
    localparam pio_state_t ST_RDATA = 3'd2;
    localparam pio_state_t ST_ACK   = 3'd3;
    localparam pio_state_t ST_DONE  = 3'd4;

    // Number of dword-select bits in a PIO address for a row of the given width.
    function automatic int lane_nbits(input int width);
        return $clog2(width / 32);
    endfunction

    // Byte enables covering one 32-bit lane of a row up to 256 bits wide.
    function automatic logic [31:0] lane_be(input logic [31:0] lane);
        return 32'hF << (lane * 4);
    endfunction

endpackage

// File: rtl/ram_dual_be_bram.sv
// True dual-port block RAM with per-byte write enables, registered read data,
// and read-first behaviour on both ports.
module ram_dual_be_bram #(
    parameter int WIDTH       = 64,
    parameter int DEPTH_NBITS = 10
) (
    input  logic                   clk_i,
    input  logic [WIDTH/8-1:0]     wea_i,
    input  logic [DEPTH_NBITS-1:0] addra_i,
    input  logic [WIDTH-1:0]       dina_i,
    output logic [WIDTH-1:0]       douta_o,
    input  logic [WIDTH/8-1:0]     web_i,
    input  logic [DEPTH_NBITS-1:0] addrb_i,
    input  logic [WIDTH-1:0]       dinb_i,
    output logic [WIDTH-1:0]       doutb_o
);

    logic [WIDTH-1:0] mem_q [2**DEPTH_NBITS];

    // Both ports share one process; a same-row write collision is undefined anyway.
    always_ff @(posedge clk_i) begin
        douta_o <= mem_q[addra_i];
        doutb_o <= mem_q[addrb_i];
        for (int i = 0; i < WIDTH / 8; i++) begin
            if (wea_i[i]) mem_q[addra_i][8*i +: 8] <= dina_i[8*i +: 8];
            if (web_i[i]) mem_q[addrb_i][8*i +: 8] <= dinb_i[8*i +: 8];
        end
    end

endmodule

// File: rtl/pio_rw_wide_dmem_bram.sv
// Wide BRAM data memory: port A belongs to the application, port B is shared with PIO.
// Define PIO_DMEM_STARVE_EN to force a PIO grant after STARVE_LIMIT waiting cycles.
module pio_rw_wide_dmem_bram
    import pio_dmem_pkg::*;
#(
    parameter int   WIDTH        = 64,
    parameter int   DEPTH_NBITS  = 10,
    parameter logic REG_WR_EN    = 1'b1,
    parameter int   STARVE_LIMIT = 4
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   clk_div_i,
    input  logic [`PIO_RANGE]      reg_addr_i,
    input  logic [`PIO_RANGE]      reg_din_i,
    input  logic                   reg_rd_i,
    input  logic                   reg_wr_i,
    input  logic                   reg_ms_i,
    input  logic [WIDTH/8-1:0]     wea_i,
    input  logic [DEPTH_NBITS-1:0] addra_i,
    input  logic [WIDTH-1:0]       dina_i,
    output logic [WIDTH-1:0]       douta_o,
    input  logic                   app_rd_i,
    input  logic [WIDTH/8-1:0]     web_i,
    input  logic [DEPTH_NBITS-1:0] addrb_i,
    input  logic [WIDTH-1:0]       dinb_i,
    output logic [WIDTH-1:0]       doutb_o,
    output logic                   app_stall_o,
    output logic                   mem_ack_o,
    output logic [`PIO_RANGE]      mem_rdata_o,
    output logic                   pio_ovr_o
);

    localparam int LANES      = WIDTH / 32;
    localparam int LANE_NBITS = lane_nbits(WIDTH);
    localparam int LANE_W     = (LANE_NBITS > 0) ? LANE_NBITS : 1;
    localparam int BE_W       = WIDTH / 8;

    pio_state_t             state_q, state_d;
    logic                   op_wr_q, op_wr_d;
    logic [DEPTH_NBITS-1:0] row_q, row_d;
    logic [LANE_W-1:0]      lane_q, lane_d;
    logic [31:0]            wdata_q, wdata_d;
    logic                   mem_ack_q, mem_ack_d;
    logic [`PIO_RANGE]      mem_rdata_q, mem_rdata_d;
    logic                   pio_ovr_q, pio_ovr_d;

    logic                   pio_req;
    logic [DEPTH_NBITS-1:0] req_row;
    logic [LANE_W-1:0]      req_lane;
    logic                   app_busy;
    logic                   pend;
    logic                   force_grant;
    logic                   grant;
    logic [31:0]            be_all;
    logic [BE_W-1:0]        pio_we;
    logic [BE_W-1:0]        ram_web;
    logic [DEPTH_NBITS-1:0] ram_addrb;
    logic [WIDTH-1:0]       ram_dinb;
    logic [WIDTH-1:0]       lane_shift;
    logic                   unused_bits;

    assign pio_req = (reg_rd_i | reg_wr_i) & reg_ms_i;
    assign req_row = reg_addr_i[2+LANE_NBITS +: DEPTH_NBITS];

    generate
        if (LANE_NBITS > 0) begin : g_lane
            assign req_lane = reg_addr_i[2 +: LANE_W];
        end else begin : g_no_lane
            assign req_lane = '0;
        end
    endgenerate

    assign app_busy = app_rd_i | (|web_i);
    assign pend     = (state_q == ST_PEND);
    assign grant    = pend & (~app_busy | force_grant);

`ifdef PIO_DMEM_STARVE_EN
    logic [3:0] wait_cnt_q, wait_cnt_d;

    // Counter is held at zero while idle, so it starts from zero on every entry to PEND.
    always_comb begin
        wait_cnt_d = wait_cnt_q;
        if (state_q == ST_IDLE) begin
            wait_cnt_d = '0;
        end else if (pend && !grant) begin
            wait_cnt_d = wait_cnt_q + 4'd1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) wait_cnt_q <= '0;
        else       wait_cnt_q <= wait_cnt_d;
    end

    assign force_grant = pend && (wait_cnt_q == 4'(STARVE_LIMIT));
    assign unused_bits = ^{reg_addr_i, reg_din_i};
`else
    assign force_grant = 1'b0;
    assign unused_bits = ^{reg_addr_i, reg_din_i, 4'(STARVE_LIMIT)};
`endif

    assign app_stall_o = force_grant;

    assign be_all    = lane_be(32'(lane_q));
    assign pio_we    = (op_wr_q && REG_WR_EN) ? be_all[BE_W-1:0] : '0;
    assign ram_web   = grant ? pio_we : web_i;
    assign ram_addrb = grant ? row_q : addrb_i;
    assign ram_dinb  = grant ? {LANES{wdata_q}} : dinb_i;

    ram_dual_be_bram #(
        .WIDTH       (WIDTH),
        .DEPTH_NBITS (DEPTH_NBITS)
    ) u_ram (
        .clk_i   (clk_i),
        .wea_i   (wea_i),
        .addra_i (addra_i),
        .dina_i  (dina_i),
        .douta_o (douta_o),
        .web_i   (ram_web),
        .addrb_i (ram_addrb),
        .dinb_i  (ram_dinb),
        .doutb_o (doutb_o)
    );

    assign lane_shift = doutb_o >> {lane_q, 5'b0};
    assign pio_ovr_d  = pio_req & (state_q != ST_IDLE);

    always_comb begin
        state_d     = state_q;
        op_wr_d     = op_wr_q;
        row_d       = row_q;
        lane_d      = lane_q;
        wdata_d     = wdata_q;
        mem_ack_d   = mem_ack_q;
        mem_rdata_d = mem_rdata_q;
        case (state_q)
            ST_IDLE: begin
                if (pio_req) begin
                    state_d = ST_PEND;
                    op_wr_d = reg_wr_i & ~reg_rd_i;
                    row_d   = req_row;
                    lane_d  = req_lane;
                    wdata_d = reg_din_i[31:0];
                end
            end
            ST_PEND: begin
                if (grant) state_d = op_wr_q ? ST_ACK : ST_RDATA;
            end
            ST_RDATA: begin
                mem_rdata_d       = '0;
                mem_rdata_d[31:0] = lane_shift[31:0];
                state_d           = ST_ACK;
            end
            ST_ACK: begin
                if (clk_div_i) begin
                    mem_ack_d = 1'b1;
                    state_d   = ST_DONE;
                end
            end
            ST_DONE: begin
                if (clk_div_i) begin
                    mem_ack_d = 1'b0;
                    state_d   = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= ST_IDLE;
            op_wr_q     <= 1'b0;
            row_q       <= '0;
            lane_q      <= '0;
            wdata_q     <= '0;
            mem_ack_q   <= 1'b0;
            mem_rdata_q <= '0;
            pio_ovr_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            op_wr_q     <= op_wr_d;
            row_q       <= row_d;
            lane_q      <= lane_d;
            wdata_q     <= wdata_d;
            mem_ack_q   <= mem_ack_d;
            mem_rdata_q <= mem_rdata_d;
            pio_ovr_q   <= pio_ovr_d;
        end
    end

    assign mem_ack_o   = mem_ack_q;
    assign mem_rdata_o = mem_rdata_q;
    assign pio_ovr_o   = pio_ovr_q;

endmodule
